input_shift_register: RTL and testbench
=======================================

INPUT_SHIFT_REGISTER -- requirements
Module: input_shift_register

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: data_in  in  32  IN source data; bits [n-1:0] are shifted in.
REQ-004 SHALL have ports: in_en  in  1  IN instruction strobe, one cycle.
REQ-005 SHALL have ports: in_count  in  6  bits to shift, 1..32; value 0 or >32 means 32.
REQ-006 SHALL have ports: shiftdir  in  1  0 = shift left, 1 = shift right.
REQ-007 SHALL have ports: push_req  in  1  PUSH instruction strobe; push_block  in  1  1 = blocking PUSH.
REQ-008 SHALL have ports: mov_load  in  1  MOV-to-ISR strobe; mov_data  in  32  MOV source.
REQ-009 SHALL have ports: autopush_en  in  1  autopush enable; push_thresh  in  6  threshold 1..32, 0 means 32.
REQ-010 SHALL have ports: isr  out  32  current ISR, readable by FSM for MOV.
REQ-011 SHALL have ports: shift_cnt  out  6  input shift counter, 0..32.
REQ-012 SHALL have ports: fifo_wdata  out  32; fifo_wvalid  out  1; fifo_wready  in  1  RX FIFO write handshake.
REQ-013 SHALL have ports: stall  out  1  FSM must hold current instruction.

Function
REQ-014 SHALL implement states IDLE and PUSH; PUSH holds fifo_wvalid=1, stall=1.
REQ-015 SHALL, in IDLE, honour strobes in priority mov_load > push_req > in_en; lower-priority strobes that cycle are ignored.
REQ-016 SHALL, on in_en with n bits, left shift: isr <= (isr << n) | data_in[n-1:0]; right shift: isr <= (isr >> n) | (data_in[n-1:0] << (32-n)); n=32: isr <= data_in.
REQ-017 SHALL update shift_cnt <= min(shift_cnt + n, 32) on in_en (saturating, 7-bit intermediate).
REQ-018 SHALL, on mov_load, set isr <= mov_data and shift_cnt <= 0.
REQ-019 SHALL, after an in_en cycle in which updated shift_cnt >= threshold and autopush_en=1, enter PUSH next cycle with fifo_wdata = updated isr.
REQ-020 SHALL, on push_req with push_block=1, enter PUSH next cycle with fifo_wdata = isr.
REQ-021 SHALL, on push_req with push_block=0: if fifo_wready=1, enter PUSH; else discard data, clear isr and shift_cnt, stay IDLE, no stall.
REQ-022 SHALL keep fifo_wdata/fifo_wvalid stable in PUSH until fifo_wvalid && fifo_wready, then next cycle clear isr and shift_cnt to 0 and return to IDLE.
REQ-023 SHALL register fifo_wvalid and stall; no combinational path from fifo_wready to any output.
REQ-024 SHALL ignore in_en, push_req, mov_load while in PUSH.
REQ-025 SHALL assert stall combinationally in IDLE only when push_req with push_block=1 is present (transfer latency minimum 1 cycle).

Reset
REQ-026 SHALL, on rst_n low, asynchronously set isr=0, shift_cnt=0, fifo_wdata=0, fifo_wvalid=0, stall=0, state=IDLE, including mid-PUSH (pending push dropped).

Configuration
REQ-027 SHALL, with macro PIO_ISR_AUTOPUSH_EN defined, implement REQ-019.
REQ-028 SHALL, without PIO_ISR_AUTOPUSH_EN, keep autopush_en/push_thresh ports but ignore them; PUSH entered only via push_req.

Structure
REQ-029 SHALL take ISR state enum (ISR_IDLE, ISR_PUSH) and constants ISR_WIDTH=32, ISR_CNT_W=6 from shared package pio_pkg.
REQ-030 SHALL be a single module with no sub-modules; shift-merge logic in one always_comb block.

Verification
REQ-031 Left: isr=0, in_en n=8 data_in=0xAB, then n=8 data_in=0xCD -> isr=0x0000ABCD, shift_cnt=16.
REQ-032 Right: isr=0, in_en n=4 data_in=0xF -> isr=0xF0000000, shift_cnt=4; n=32 0x12345678 -> isr=0x12345678, shift_cnt=32.
REQ-033 Autopush: thresh=16, two IN n=8 (0x11,0x22), fifo_wready=1 -> fifo_wvalid one cycle after 2nd IN, fifo_wdata=0x00001122, then isr=0, shift_cnt=0.
REQ-034 Blocking PUSH, fifo_wready=0 for 5 cycles -> stall and fifo_wvalid high 5 cycles, fifo_wdata stable; in_en during stall has no effect.
REQ-035 Non-blocking PUSH with fifo_wready=0 -> no fifo_wvalid, isr=0, shift_cnt=0, stall=0.
REQ-036 rst_n low while in PUSH -> fifo_wvalid=0 immediately, all outputs 0; mov_load+in_en same cycle -> isr=mov_data, shift_cnt=0.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared PIO definitions: ISR state encoding, widths and a count-normalisation helper.

package pio_pkg;

   localparam int unsigned ISR_WIDTH = 32;
   localparam int unsigned ISR_CNT_W = 6;

   localparam logic [ISR_CNT_W-1:0] ISR_CNT_FULL = ISR_CNT_W'(ISR_WIDTH);

   typedef enum logic {
      ISR_IDLE,
      ISR_PUSH
   } isr_state_e;

   // Bit counts and thresholds use 0 (and anything past the register width) to mean "full word".
   function automatic logic [ISR_CNT_W-1:0] eff_count(input logic [ISR_CNT_W-1:0] v);
      if ((v == '0) || (v > ISR_CNT_FULL)) begin
         return ISR_CNT_FULL;
      end
      return v;
   endfunction

endpackage

// File: rtl/input_shift_register.sv
// PIO input shift register: IN shifting, MOV load, PUSH to RX FIFO with blocking/non-blocking
// behaviour. Autopush is compiled in only when PIO_ISR_AUTOPUSH_EN is defined.

module input_shift_register
   import pio_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ISR_WIDTH-1:0] data_in,
   input  logic                 in_en,
   input  logic [ISR_CNT_W-1:0] in_count,
   input  logic                 shiftdir,
   input  logic                 push_req,
   input  logic                 push_block,
   input  logic                 mov_load,
   input  logic [ISR_WIDTH-1:0] mov_data,
   input  logic                 autopush_en,
   input  logic [ISR_CNT_W-1:0] push_thresh,
   output logic [ISR_WIDTH-1:0] isr,
   output logic [ISR_CNT_W-1:0] shift_cnt,
   output logic [ISR_WIDTH-1:0] fifo_wdata,
   output logic                 fifo_wvalid,
   input  logic                 fifo_wready,
   output logic                 stall
);

   isr_state_e           state_q, state_d;
   logic [ISR_WIDTH-1:0] isr_q, isr_d;
   logic [ISR_CNT_W-1:0] cnt_q, cnt_d;
   logic [ISR_WIDTH-1:0] wdata_q, wdata_d;
   logic                 wvalid_q, wvalid_d;
   logic                 stall_q, stall_d;
   logic                 stall_idle;

   logic [ISR_CNT_W-1:0] n_eff;
   logic [ISR_WIDTH-1:0] data_mask;
   logic [ISR_WIDTH-1:0] shifted;
   logic [ISR_CNT_W:0]   cnt_sum;
   logic [ISR_CNT_W-1:0] cnt_sat;
   logic                 autopush_hit;

   // Shift-merge of the incoming bits and saturating count update.
   always_comb begin
      n_eff     = eff_count(in_count);
      data_mask = '0;
      shifted   = data_in;
      if (n_eff != ISR_CNT_FULL) begin
         data_mask = (ISR_WIDTH'(1) << n_eff) - ISR_WIDTH'(1);
         if (shiftdir) begin
            shifted = (isr_q >> n_eff) | ((data_in & data_mask) << (ISR_CNT_FULL - n_eff));
         end else begin
            shifted = (isr_q << n_eff) | (data_in & data_mask);
         end
      end
      cnt_sum = {1'b0, cnt_q} + {1'b0, n_eff};
      cnt_sat = (cnt_sum > {1'b0, ISR_CNT_FULL}) ? ISR_CNT_FULL : cnt_sum[ISR_CNT_W-1:0];
   end

`ifdef PIO_ISR_AUTOPUSH_EN
   assign autopush_hit = autopush_en && (cnt_sat >= eff_count(push_thresh));
`else
   logic unused_autopush_cfg;
   assign unused_autopush_cfg = ^{autopush_en, push_thresh};
   assign autopush_hit        = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      isr_d      = isr_q;
      cnt_d      = cnt_q;
      wdata_d    = wdata_q;
      wvalid_d   = wvalid_q;
      stall_d    = stall_q;
      stall_idle = 1'b0;
      unique case (state_q)
         ISR_IDLE: begin
            if (mov_load) begin
               isr_d = mov_data;
               cnt_d = '0;
            end else if (push_req) begin
               stall_idle = push_block;
               if (push_block || fifo_wready) begin
                  state_d  = ISR_PUSH;
                  wdata_d  = isr_q;
                  wvalid_d = 1'b1;
                  stall_d  = 1'b1;
               end else begin
                  // Non-blocking push into a full FIFO drops the data.
                  isr_d = '0;
                  cnt_d = '0;
               end
            end else if (in_en) begin
               isr_d = shifted;
               cnt_d = cnt_sat;
               if (autopush_hit) begin
                  state_d  = ISR_PUSH;
                  wdata_d  = shifted;
                  wvalid_d = 1'b1;
                  stall_d  = 1'b1;
               end
            end
         end
         ISR_PUSH: begin
            if (fifo_wready) begin
               state_d  = ISR_IDLE;
               isr_d    = '0;
               cnt_d    = '0;
               wvalid_d = 1'b0;
               stall_d  = 1'b0;
            end
         end
         default: state_d = ISR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ISR_IDLE;
         isr_q    <= '0;
         cnt_q    <= '0;
         wdata_q  <= '0;
         wvalid_q <= 1'b0;
         stall_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         isr_q    <= isr_d;
         cnt_q    <= cnt_d;
         wdata_q  <= wdata_d;
         wvalid_q <= wvalid_d;
         stall_q  <= stall_d;
      end
   end

   assign isr         = isr_q;
   assign shift_cnt   = cnt_q;
   assign fifo_wdata  = wdata_q;
   assign fifo_wvalid = wvalid_q;
   // stall_idle depends only on instruction strobes, never on fifo_wready.
   assign stall       = stall_q | stall_idle;

endmodule

// File: tb/tb_input_shift_register.sv
// Self-checking bench for input_shift_register: table of IN/MOV vectors plus PUSH and reset
// sequences. Autopush expectations follow PIO_ISR_AUTOPUSH_EN.

module tb_input_shift_register;

   logic        clk;
   logic        rst_n;
   logic [31:0] data_in;
   logic        in_en;
   logic [5:0]  in_count;
   logic        shiftdir;
   logic        push_req;
   logic        push_block;
   logic        mov_load;
   logic [31:0] mov_data;
   logic        autopush_en;
   logic [5:0]  push_thresh;
   logic [31:0] isr;
   logic [5:0]  shift_cnt;
   logic [31:0] fifo_wdata;
   logic        fifo_wvalid;
   logic        fifo_wready;
   logic        stall;

   int checks;
   int errors;

   input_shift_register dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .in_en       (in_en),
      .in_count    (in_count),
      .shiftdir    (shiftdir),
      .push_req    (push_req),
      .push_block  (push_block),
      .mov_load    (mov_load),
      .mov_data    (mov_data),
      .autopush_en (autopush_en),
      .push_thresh (push_thresh),
      .isr         (isr),
      .shift_cnt   (shift_cnt),
      .fifo_wdata  (fifo_wdata),
      .fifo_wvalid (fifo_wvalid),
      .fifo_wready (fifo_wready),
      .stall       (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mov;
      logic [31:0] mdata;
      logic        in;
      logic [5:0]  n;
      logic        dir;
      logic [31:0] din;
      logic [31:0] exp_isr;
      logic [5:0]  exp_cnt;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_strobes();
      in_en    = 1'b0;
      push_req = 1'b0;
      mov_load = 1'b0;
   endtask

   task automatic do_mov(input logic [31:0] v);
      clear_strobes();
      mov_load = 1'b1;
      mov_data = v;
      step();
      mov_load = 1'b0;
   endtask

   task automatic do_in(input logic [5:0] n, input logic dir, input logic [31:0] d);
      clear_strobes();
      in_en    = 1'b1;
      in_count = n;
      shiftdir = dir;
      data_in  = d;
      step();
      in_en = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      vecs[0]  = '{1'b0, 32'h0,        1'b1, 6'd8,  1'b0, 32'h0000_00AB, 32'h0000_00AB, 6'd8};
      vecs[1]  = '{1'b0, 32'h0,        1'b1, 6'd8,  1'b0, 32'h0000_00CD, 32'h0000_ABCD, 6'd16};
      vecs[2]  = '{1'b1, 32'h0,        1'b0, 6'd0,  1'b0, 32'h0,         32'h0,         6'd0};
      vecs[3]  = '{1'b0, 32'h0,        1'b1, 6'd4,  1'b1, 32'h0000_000F, 32'hF000_0000, 6'd4};
      vecs[4]  = '{1'b0, 32'h0,        1'b1, 6'd32, 1'b1, 32'h1234_5678, 32'h1234_5678, 6'd32};
      vecs[5]  = '{1'b0, 32'h0,        1'b1, 6'd8,  1'b0, 32'hFFFF_FF01, 32'h3456_7801, 6'd32};
      vecs[6]  = '{1'b1, 32'hDEAD_BEEF, 1'b1, 6'd8, 1'b0, 32'h0000_0011, 32'hDEAD_BEEF, 6'd0};
      vecs[7]  = '{1'b0, 32'h0,        1'b1, 6'd0,  1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 6'd32};
      vecs[8]  = '{1'b1, 32'h8000_0001, 1'b0, 6'd0, 1'b0, 32'h0,         32'h8000_0001, 6'd0};
      vecs[9]  = '{1'b0, 32'h0,        1'b1, 6'd40, 1'b1, 32'h0000_0055, 32'h0000_0055, 6'd32};
      vecs[10] = '{1'b1, 32'h0000_000F, 1'b0, 6'd0, 1'b0, 32'h0,         32'h0000_000F, 6'd0};
      vecs[11] = '{1'b0, 32'h0,        1'b1, 6'd1,  1'b1, 32'h0000_0001, 32'h8000_0007, 6'd1};
      vecs[12] = '{1'b0, 32'h0,        1'b1, 6'd3,  1'b0, 32'h0000_00FF, 32'h0000_003F, 6'd4};

      rst_n       = 1'b0;
      data_in     = '0;
      in_en       = 1'b0;
      in_count    = '0;
      shiftdir    = 1'b0;
      push_req    = 1'b0;
      push_block  = 1'b0;
      mov_load    = 1'b0;
      mov_data    = '0;
      autopush_en = 1'b0;
      push_thresh = '0;
      fifo_wready = 1'b0;
      #12;
      check("reset isr", isr, 32'h0);
      check("reset shift_cnt", 32'(shift_cnt), 32'd0);
      check("reset fifo_wdata", fifo_wdata, 32'h0);
      check("reset fifo_wvalid", 32'(fifo_wvalid), 32'd0);
      check("reset stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      foreach (vecs[i]) begin
         mov_load = vecs[i].mov;
         mov_data = vecs[i].mdata;
         in_en    = vecs[i].in;
         in_count = vecs[i].n;
         shiftdir = vecs[i].dir;
         data_in  = vecs[i].din;
         step();
         check($sformatf("vec%0d isr", i), isr, vecs[i].exp_isr);
         check($sformatf("vec%0d shift_cnt", i), 32'(shift_cnt), 32'(vecs[i].exp_cnt));
         check($sformatf("vec%0d fifo_wvalid", i), 32'(fifo_wvalid), 32'd0);
      end
      clear_strobes();

      // Autopush at threshold 16 after two 8-bit INs.
      do_mov(32'h0);
      autopush_en = 1'b1;
      push_thresh = 6'd16;
      fifo_wready = 1'b1;
      do_in(6'd8, 1'b0, 32'h0000_0011);
      check("autopush first IN no push", 32'(fifo_wvalid), 32'd0);
      do_in(6'd8, 1'b0, 32'h0000_0022);
`ifdef PIO_ISR_AUTOPUSH_EN
      check("autopush wvalid", 32'(fifo_wvalid), 32'd1);
      check("autopush wdata", fifo_wdata, 32'h0000_1122);
      check("autopush stall", 32'(stall), 32'd1);
      step();
      check("autopush done wvalid", 32'(fifo_wvalid), 32'd0);
      check("autopush done isr", isr, 32'h0);
      check("autopush done cnt", 32'(shift_cnt), 32'd0);
`else
      check("no autopush wvalid", 32'(fifo_wvalid), 32'd0);
      check("no autopush isr", isr, 32'h0000_1122);
      check("no autopush cnt", 32'(shift_cnt), 32'd16);
`endif
      autopush_en = 1'b0;
      fifo_wready = 1'b0;

      // Blocking PUSH held off by the FIFO for 5 cycles; IN during the stall is ignored.
      do_mov(32'hA5A5_A5A5);
      push_req   = 1'b1;
      push_block = 1'b1;
      #1;
      check("blocking push comb stall", 32'(stall), 32'd1);
      step();
      push_req = 1'b0;
      in_en    = 1'b1;
      in_count = 6'd8;
      data_in  = 32'h0000_00FF;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("block c%0d wvalid", c), 32'(fifo_wvalid), 32'd1);
         check($sformatf("block c%0d stall", c), 32'(stall), 32'd1);
         check($sformatf("block c%0d wdata", c), fifo_wdata, 32'hA5A5_A5A5);
         check($sformatf("block c%0d isr", c), isr, 32'hA5A5_A5A5);
         if (c < 4) step();
      end
      fifo_wready = 1'b1;
      step();
      in_en = 1'b0;
      check("block done wvalid", 32'(fifo_wvalid), 32'd0);
      check("block done stall", 32'(stall), 32'd0);
      check("block done isr", isr, 32'h0);
      check("block done cnt", 32'(shift_cnt), 32'd0);

      // Non-blocking PUSH into a full FIFO discards the ISR.
      fifo_wready = 1'b0;
      do_mov(32'h1234_5678);
      do_in(6'd4, 1'b0, 32'h0000_0009);
      push_req   = 1'b1;
      push_block = 1'b0;
      #1;
      check("nb push comb stall", 32'(stall), 32'd0);
      step();
      push_req = 1'b0;
      check("nb full wvalid", 32'(fifo_wvalid), 32'd0);
      check("nb full isr", isr, 32'h0);
      check("nb full cnt", 32'(shift_cnt), 32'd0);
      check("nb full stall", 32'(stall), 32'd0);

      // Non-blocking PUSH with room completes in one PUSH cycle.
      do_mov(32'h0000_0077);
      fifo_wready = 1'b1;
      push_req    = 1'b1;
      step();
      push_req = 1'b0;
      check("nb ready wvalid", 32'(fifo_wvalid), 32'd1);
      check("nb ready wdata", fifo_wdata, 32'h0000_0077);
      step();
      check("nb ready done wvalid", 32'(fifo_wvalid), 32'd0);
      check("nb ready done isr", isr, 32'h0);

      // MOV outranks PUSH: no stall, ISR loaded, no transfer.
      mov_load   = 1'b1;
      mov_data   = 32'h5555_AAAA;
      push_req   = 1'b1;
      push_block = 1'b1;
      #1;
      check("mov over push comb stall", 32'(stall), 32'd0);
      step();
      clear_strobes();
      check("mov over push isr", isr, 32'h5555_AAAA);
      check("mov over push wvalid", 32'(fifo_wvalid), 32'd0);

      // Asynchronous reset while a PUSH is pending.
      fifo_wready = 1'b0;
      do_mov(32'h0BAD_F00D);
      push_req = 1'b1;
      step();
      push_req = 1'b0;
      check("pre-reset wvalid", 32'(fifo_wvalid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid-push reset wvalid", 32'(fifo_wvalid), 32'd0);
      check("mid-push reset stall", 32'(stall), 32'd0);
      check("mid-push reset isr", isr, 32'h0);
      check("mid-push reset wdata", fifo_wdata, 32'h0);
      check("mid-push reset cnt", 32'(shift_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post-reset wvalid", 32'(fifo_wvalid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
